// File: rtl/exu_mul_arb.sv
// exu_mul_arb: two-port round-robin arbiter feeding one shared multiplier,
// with a one-entry holding buffer per port and saturating per-port issue counters.
module exu_mul_arb #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int REG_DATA_WIDTH  = 32,
  parameter int COMMIT_ID_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            int_assert_i,
  input  logic [1:0]                      req_valid_i,
  input  logic [1:0][3:0]                 req_op_i,
  input  logic [1:0][REG_DATA_WIDTH-1:0]  req_rs1_i,
  input  logic [1:0][REG_DATA_WIDTH-1:0]  req_rs2_i,
  input  logic [1:0][REG_ADDR_WIDTH-1:0]  req_waddr_i,
  input  logic [1:0][COMMIT_ID_WIDTH-1:0] req_commit_id_i,
  output logic [1:0]                      req_ready_o,
  output logic                            mul_valid_o,
  output logic [3:0]                      mul_op_o,
  output logic [REG_DATA_WIDTH-1:0]       mul_rs1_o,
  output logic [REG_DATA_WIDTH-1:0]       mul_rs2_o,
  output logic [REG_ADDR_WIDTH-1:0]       mul_waddr_o,
  output logic [COMMIT_ID_WIDTH-1:0]      mul_commit_id_o,
  input  logic                            mul_ready_i,
  output logic                            grant_port_o,
  output logic [15:0]                     grant_cnt0_o,
  output logic [15:0]                     grant_cnt1_o
);
  typedef struct packed {
    logic [3:0]                 op;
    logic [REG_DATA_WIDTH-1:0]  rs1;
    logic [REG_DATA_WIDTH-1:0]  rs2;
    logic [REG_ADDR_WIDTH-1:0]  waddr;
    logic [COMMIT_ID_WIDTH-1:0] cid;
  } pay_t;

  pay_t [1:0]       buf_q, buf_d, live_pay, cand;
  logic [1:0]       bv_q, bv_d, cand_v, gsel, iss_p, live, cap;
  logic [1:0][15:0] cnt_q, cnt_d;
  logic             rr_q, rr_d, gnt, issue;

  always_comb begin
    cand_v = bv_q | (req_valid_i & {2{~int_assert_i}});
    gnt = &cand_v ? ~rr_q : cand_v[1];
    gsel = {gnt, ~gnt};
    mul_valid_o = |cand_v & ~int_assert_i;
    issue = mul_valid_o & mul_ready_i;
    iss_p = {2{issue}} & gsel;
    // A full buffer frees its slot only in the cycle it actually issues
    req_ready_o = {2{~int_assert_i}} & (~bv_q | (gsel & {2{mul_ready_i}}));
    live = req_valid_i & req_ready_o;
    cap = live & (bv_q | ~iss_p);
    bv_d = {2{~int_assert_i}} & (cap | (bv_q & ~iss_p));
    for (int i = 0; i < 2; i++) begin
      live_pay[i] = {req_op_i[i], req_rs1_i[i], req_rs2_i[i], req_waddr_i[i], req_commit_id_i[i]};
      cand[i] = bv_q[i] ? buf_q[i] : live_pay[i];
      buf_d[i] = cap[i] ? live_pay[i] : buf_q[i];
      cnt_d[i] = cnt_q[i] + 16'(iss_p[i] & ~&cnt_q[i]);
    end
    rr_d = issue ? gnt : rr_q;
    {mul_op_o, mul_rs1_o, mul_rs2_o, mul_waddr_o, mul_commit_id_o} = |cand_v ? cand[gnt] : '0;
    grant_port_o = gnt;
  end

  assign grant_cnt0_o = cnt_q[0];
  assign grant_cnt1_o = cnt_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bv_q  <= '0;
      buf_q <= '0;
      cnt_q <= '0;
      rr_q  <= 1'b0;
    end else begin
      bv_q  <= bv_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
    end
  end
endmodule

// File: tb/tb_exu_mul_arb.sv
// tb_exu_mul_arb: scoreboard bench for exu_mul_arb; expected issues are queued
// when driven and compared in issue order by a monitor.
module tb_exu_mul_arb;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             int_assert;
  logic [1:0]       req_valid;
  logic [1:0][3:0]  req_op;
  logic [1:0][31:0] req_rs1, req_rs2;
  logic [1:0][4:0]  req_waddr;
  logic [1:0][3:0]  req_cid;
  logic [1:0]       req_ready;
  logic             mul_valid, mul_ready, grant_port;
  logic [3:0]       mul_op, mul_cid;
  logic [31:0]      mul_rs1, mul_rs2;
  logic [4:0]       mul_waddr;
  logic [15:0]      cnt0, cnt1;
  logic [127:0]     sb_q[$];
  int               n_chk = 0, n_pass = 0;

  exu_mul_arb #(.REG_ADDR_WIDTH(5), .REG_DATA_WIDTH(32), .COMMIT_ID_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .int_assert_i(int_assert),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .req_waddr_i(req_waddr), .req_commit_id_i(req_cid), .req_ready_o(req_ready),
    .mul_valid_o(mul_valid), .mul_op_o(mul_op), .mul_rs1_o(mul_rs1), .mul_rs2_o(mul_rs2),
    .mul_waddr_o(mul_waddr), .mul_commit_id_o(mul_cid), .mul_ready_i(mul_ready),
    .grant_port_o(grant_port), .grant_cnt0_o(cnt0), .grant_cnt1_o(cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pk(input logic p, input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] wa, input logic [3:0] cid);
    return {50'b0, p, op, a, b, wa, cid};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic put(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] cid, input bit exp);
    req_valid[p] = 1'b1;
    req_op[p] = op;
    req_rs1[p] = a;
    req_rs2[p] = b;
    req_waddr[p] = {1'b0, cid};
    req_cid[p] = cid;
    if (exp) sb_q.push_back(pk(p[0], op, a, b, {1'b0, cid}, cid));
  endtask

  task automatic step();
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && mul_valid && mul_ready) begin
      if (sb_q.size() == 0) chk("spurious_issue", 1, 0);
      else chk("issue", pk(grant_port, mul_op, mul_rs1, mul_rs2, mul_waddr, mul_cid), sb_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; int_assert = 1'b0; mul_ready = 1'b1;
    req_valid = '0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_waddr = '0; req_cid = '0;
    @(negedge clk);
    chk("rst_valid", mul_valid, 0);
    chk("rst_ready", req_ready, 2'b11);
    chk("rst_cnt", {cnt1, cnt0}, 0);
    chk("rst_gport", grant_port, 0);
    chk("rst_payload", {mul_op, mul_rs1, mul_rs2, mul_waddr, mul_cid}, 0);
    sync();
    rst_n = 1'b1;

    // single request on an idle port issues in the same cycle
    sync();
    put(0, 4'b0001, 7, 6, 4'd1, 1);
    @(negedge clk);
    chk("solo_valid", mul_valid, 1);
    chk("solo_rs1", mul_rs1, 7);
    chk("solo_gport", grant_port, 0);
    step();
    @(negedge clk);
    chk("solo_cnt0", cnt0, 1);
    chk("solo_idle", mul_valid, 0);

    // ties after reset: port 1 first, buffered port 0 next, then port 1 again
    do_reset();
    put(1, 4'b0010, 32'h100, 32'h101, 4'd3, 1);
    put(0, 4'b0100, 32'h200, 32'h201, 4'd2, 1);
    @(negedge clk);
    chk("tie1_gport", grant_port, 1);
    chk("tie1_ready", req_ready, 2'b11);
    step();
    @(negedge clk);
    chk("tie1_buf_gport", grant_port, 0);
    chk("tie1_buf_ready0", req_ready[0], 1);
    step();
    put(1, 4'b0010, 32'h110, 32'h111, 4'd5, 1);
    put(0, 4'b0100, 32'h210, 32'h211, 4'd4, 1);
    @(negedge clk);
    chk("tie2_gport", grant_port, 1);
    step();
    @(negedge clk);
    chk("tie2_buf_gport", grant_port, 0);
    step();
    @(negedge clk);
    chk("tie_cnts", {cnt1, cnt0}, {16'd2, 16'd2});

    // multiplier stalled for three cycles
    sync();
    mul_ready = 1'b0;
    put(0, 4'b1000, 32'd20, 32'd21, 4'd6, 1);
    @(negedge clk);
    chk("stall_valid", mul_valid, 1);
    step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_ready0", req_ready[0], 0);
      chk("stall_rs1", mul_rs1, 20);
      chk("stall_valid_hold", mul_valid, 1);
      step();
    end
    mul_ready = 1'b1;
    @(negedge clk);
    chk("unstall_ready0", req_ready[0], 1);
    chk("unstall_valid", mul_valid, 1);
    step();
    @(negedge clk);
    chk("unstall_cnt0", cnt0, 3);

    // both buffers full, then a one-cycle flush
    sync();
    mul_ready = 1'b0;
    put(0, 4'b0001, 32'h300, 32'h301, 4'd7, 0);
    put(1, 4'b0001, 32'h400, 32'h401, 4'd8, 0);
    step();
    int_assert = 1'b1;
    mul_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", mul_valid, 0);
    chk("flush_ready", req_ready, 2'b00);
    sync();
    int_assert = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", mul_valid, 0);
    chk("post_flush_ready", req_ready, 2'b11);
    step();
    @(negedge clk);
    chk("post_flush_idle", mul_valid, 0);
    chk("flush_cnts", {cnt1, cnt0}, {16'd2, 16'd3});

    // reset in the middle of a buffered request
    sync();
    mul_ready = 1'b0;
    put(0, 4'b0001, 32'h500, 32'h501, 4'd9, 0);
    step();
    rst_n = 1'b0;
    mul_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", mul_valid, 0);
    chk("midrst_cnt0", cnt0, 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_after", mul_valid, 0);

    // back-to-back requests through a full buffer keep order
    sync();
    mul_ready = 1'b0;
    put(0, 4'b0001, 32'h600, 32'h601, 4'd1, 1);
    step();
    mul_ready = 1'b1;
    put(0, 4'b0001, 32'h610, 32'h611, 4'd2, 1);
    @(negedge clk);
    chk("b2b_ready0_a", req_ready[0], 1);
    chk("b2b_cid_a", mul_cid, 1);
    step();
    put(0, 4'b0001, 32'h620, 32'h621, 4'd3, 1);
    @(negedge clk);
    chk("b2b_ready0_b", req_ready[0], 1);
    chk("b2b_cid_b", mul_cid, 2);
    step();
    @(negedge clk);
    chk("b2b_cid_c", mul_cid, 3);
    step();
    @(negedge clk);
    chk("b2b_idle", mul_valid, 0);
    chk("b2b_cnt0", cnt0, 3);

    // drive port-0 issues up to the counter ceiling
    sync();
    for (int k = 0; k < 65530; k++) begin
      put(0, 4'b0001, k, 32'h1, k[3:0], 1);
      sync();
    end
    req_valid = '0;
    @(negedge clk);
    chk("sat_pre", cnt0, 16'hFFFD);
    for (int k = 0; k < 3; k++) begin
      sync();
      put(0, 4'b0001, 32'h700 + k, 32'h2, 4'(k), 1);
      step();
      @(negedge clk);
      chk("sat_cnt0", cnt0, k == 0 ? 16'hFFFE : 16'hFFFF);
    end
    chk("sat_cnt1", cnt1, 0);

    sync();
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
